i2c_wr_master: RTL
==================

# i2c_wr_master

Parametrised I2C write-only master that replaces the fixed 24-bit codec configuration controller. It sends one START, a configurable number of bytes MSB-first, and a STOP. It reports slave NACKs, aborts the transfer cleanly on a NACK, and can optionally retry a failed transfer. It sits between the codec register-sequencer (which supplies `din` and `wr_i2c`) and the WM8731 control pins.

## Interface
- `NBYTES`, default 3: bytes per transfer, address byte included; legal range 1..4.
- `QDIV`, default 125: `clk` cycles per quarter SCL bit (50 MHz gives 100 kHz); legal minimum 2.
- `MAX_RETRY`, default 3: extra attempts after a NACK; used only when `I2C_RETRY_EN` is defined.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  8*NBYTES  transfer data; the top byte is sent first (slave address + R/W=0).
- `wr_i2c`  in  1  start request; sampled only in IDLE.
- `i2c_idle`  out  1  high when in IDLE and ready to accept a request.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `ack_err`  out  1  high when the last transfer ended on a NACK.
- `i2c_sclk`  out  1  SCL, push-pull (no clock stretching).
- `i2c_sdat`  inout  1  SDA, open-drain: drives 0 or releases to Z.

## Operation
- Bit timing uses a quarter counter `q` = 0..3, advanced every QDIV clocks. Each bit cell is 4 quarters.
- In DATA and ACK cells, SCL is low in q0–q1 and high in q2–q3. SDA changes only at q0 entry.
- States and transitions:
  - IDLE: SCL=1, SDA=Z. On `wr_i2c`=1: latch `din` into a shift register, clear `ack_err`, reset the byte/bit counters, go to START.
  - START (1 cell): q0–q1 SDA=Z, SCL=1; q2–q3 SDA=0, SCL=1. Then go to DATA.
  - DATA (8 cells per byte): drive shift-register MSB, shift left by 1 at the end of each cell. After 8 cells go to ACK.
  - ACK (1 cell): release SDA, sample `i2c_sdat` on the last clock of q2.
    - Sample 0 and bytes remain: go to DATA.
    - Sample 0 and last byte: go to STOP.
    - Sample 1 (NACK): go to STOP and set a NACK flag. Remaining bytes are never driven.
  - STOP (1 cell): q0–q1 SCL=0, SDA=0; q2 SCL=1, SDA=0; q3 SCL=1, SDA=Z.
  - TURN (1 cell): SCL=1, SDA=Z (bus-free time). Then go to IDLE, pulse `done`, and set `ack_err` = NACK flag.
- `wr_i2c` and `din` are ignored outside IDLE. A request held high through IDLE starts a new transfer on the cycle after `done`.
- The byte counter is sized with $clog2(NBYTES+1). The shift register is 8*NBYTES wide. There is no wrap-around: the counters are reloaded in IDLE.
- Reset values: `i2c_sclk`=1, SDA=Z, `i2c_idle`=1, `done`=0, `ack_err`=0, state=IDLE.
- Reset asserted mid-transfer forces these values asynchronously, with no STOP generated. Callers must re-initialise the codec after a mid-transfer reset.

## Timing
- The request is accepted on a clock edge with `wr_i2c`=1 in IDLE; `i2c_idle` falls on that same edge, and START q0 begins at the next cycle.
- A full ACKed transfer lasts (9*NBYTES+3)*4*QDIV clocks from acceptance to `done`. The default is 15000 clocks.
- A NACK on byte k (1-based) shortens the transfer to (9*k+3)*4*QDIV clocks.
- `done` and the final `ack_err` update happen on the same edge, and `i2c_idle` rises on that edge too.

## Configuration
- `I2C_RETRY_EN` defined:
  - After the TURN of a NACKed attempt, re-enter START with the original latched `din`, at most MAX_RETRY times. The retry counter clears on acceptance.
  - `done` and `ack_err` occur only after the final attempt; `ack_err`=1 only if the final attempt NACKs.
- `I2C_RETRY_EN` undefined: there is a single attempt and `MAX_RETRY` is unused (no retry counter is synthesised).

## Test plan
- Defaults, `din`=24'h341E00, slave ACKs all bytes -> SDA carries 0x34, 0x1E, 0x00 MSB-first, 27 SCL high pulses plus START/STOP, `done` at clock 15000, `ack_err`=0.
- Defaults, slave NACKs byte 2, retry off -> STOP follows the second ACK cell, 0x00 is never driven, `done` at 21*500=10500 clocks, `ack_err`=1. A following ACKed transfer clears `ack_err`.
- `wr_i2c` pulsed and `din` changed to 24'hFFFFFF mid-transfer -> no effect, transmitted bytes unchanged, exactly one `done`.
- `reset` low during byte 2, cell 4 -> immediately `i2c_sclk`=1, SDA=Z, `i2c_idle`=1, `ack_err`=0. After release, a new request transfers normally.
- `I2C_RETRY_EN`, MAX_RETRY=2, address NACKed twice then ACKed -> 3 START conditions, `ack_err`=0. With all attempts NACKed -> 3 attempts, then `ack_err`=1 and one `done`.
- NBYTES=1, QDIV=2, `din`=8'h34, ACK -> transfer of 12 cells, `done` at 96 clocks.

Source files
------------

// File: rtl/i2c_wr_master.sv
// i2c_wr_master: write-only I2C master. Sends START, NBYTES bytes MSB-first
// (each followed by an ACK cell), STOP, and a bus-free TURN cell, then
// returns to IDLE with a one-cycle done pulse and the NACK status in ack_err.
// Optional feature macro: I2C_RETRY_EN -- re-run a NACKed transfer up to
// MAX_RETRY extra times from the originally latched din.
//
// Handshake: a request is accepted on the rising edge where wr_i2c=1 and the
// block is in IDLE (i2c_idle=1); din is captured on that edge. wr_i2c and din
// are ignored at all other times. done pulses for exactly one cycle on the
// edge that returns the block to IDLE.
module i2c_wr_master #(
  parameter int NBYTES    = 3,
  parameter int QDIV      = 125,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*NBYTES-1:0]   din,
  input  logic                  wr_i2c,
  output logic                  i2c_idle,
  output logic                  done,
  output logic                  ack_err,
  output logic                  i2c_sclk,
  inout  wire                   i2c_sdat,
  output logic [2:0]            dbg_state
);

  localparam int DW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(QDIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_TURN  = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [DW-1:0]       div;
  logic [1:0]          q;
  logic [8*NBYTES-1:0] shreg;
  logic [2:0]          bit_cnt;
  logic [BW-1:0]       byte_cnt;
  logic                nack;

  logic tick, cell_end;
  logic accept, finish;
  logic scl, sda_low;

`ifdef I2C_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0]       retry_cnt;
  logic [8*NBYTES-1:0] din_q;
  logic                retry_go;
`endif

  // End of a quarter and end of a whole bit cell.
  assign tick     = (div == DIV_LAST);
  assign cell_end = tick && (q == 2'd3);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state, bus levels and control strobes for the datapath.
  always_comb begin
    state_n = state;
    scl     = 1'b1;
    sda_low = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
`ifdef I2C_RETRY_EN
    retry_go = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (wr_i2c) begin
          accept  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        // SDA falls mid-cell while SCL stays high.
        sda_low = q[1];
        if (cell_end) state_n = S_DATA;
      end
      S_DATA: begin
        scl     = q[1];
        sda_low = ~shreg[8*NBYTES-1];
        if (cell_end && bit_cnt == 3'd7) state_n = S_ACK;
      end
      S_ACK: begin
        scl = q[1];
        if (cell_end) begin
          if (nack || byte_cnt == BYTE_LAST) state_n = S_STOP;
          else                               state_n = S_DATA;
        end
      end
      S_STOP: begin
        // SDA held low until SCL has been high for a quarter, then released.
        scl     = q[1];
        sda_low = (q != 2'd3);
        if (cell_end) state_n = S_TURN;
      end
      S_TURN: begin
        if (cell_end) begin
`ifdef I2C_RETRY_EN
          if (nack && retry_cnt < RW'(MAX_RETRY)) begin
            retry_go = 1'b1;
            state_n  = S_START;
          end else begin
            finish  = 1'b1;
            state_n = S_IDLE;
          end
`else
          finish  = 1'b1;
          state_n = S_IDLE;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Quarter timing, shift register, counters and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      q        <= 2'd0;
      shreg    <= '0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      nack     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
`ifdef I2C_RETRY_EN
      retry_cnt <= '0;
      din_q     <= '0;
`endif
    end else begin
      done <= finish;
      if (finish) ack_err <= nack;

      if (state == S_IDLE) begin
        div <= '0;
        q   <= 2'd0;
      end else if (tick) begin
        div <= '0;
        q   <= q + 2'd1;
      end else begin
        div <= div + 1'b1;
      end

      if (accept) begin
        shreg    <= din;
        ack_err  <= 1'b0;
        nack     <= 1'b0;
        bit_cnt  <= 3'd0;
        byte_cnt <= '0;
`ifdef I2C_RETRY_EN
        din_q     <= din;
        retry_cnt <= '0;
`endif
      end

      if (state == S_DATA && cell_end) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Slave answer is taken at the end of the first SCL-high quarter.
      if (state == S_ACK && tick && q == 2'd2) nack <= i2c_sdat;
      if (state == S_ACK && cell_end) byte_cnt <= byte_cnt + 1'b1;

`ifdef I2C_RETRY_EN
      if (retry_go) begin
        shreg     <= din_q;
        nack      <= 1'b0;
        bit_cnt   <= 3'd0;
        byte_cnt  <= '0;
        retry_cnt <= retry_cnt + 1'b1;
      end
`endif
    end
  end

  assign i2c_sclk  = scl;
  assign i2c_sdat  = sda_low ? 1'b0 : 1'bz;
  assign i2c_idle  = (state == S_IDLE);
  assign dbg_state = state;

endmodule
